// File: rtl/uart_frame_pkg.sv
// Shared constants and state encoding for the UART command-frame controller.
package uart_frame_pkg;

   localparam logic [7:0] SOF_BYTE               = 8'hA5;
   localparam int         DEFAULT_MAX_LEN        = 8;
   localparam int         DEFAULT_TIMEOUT_CYCLES = 1_000_000;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      LEN,
      PAYLOAD,
      CHECK,
      HOLD
   } frame_state_t;

endpackage

// File: rtl/uart_frame_controller_timer.sv
// Inter-byte gap timer: down-counter reloaded on every byte, terminal-count
// compare raises a one-cycle expiry pulse while enabled.
module frame_timeout_timer
   import uart_frame_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clk_100MHz,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int            CW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_q, count_d;

   // Reload on a byte (the byte wins over expiry), otherwise count down.
   always_comb begin
      count_d = count_q;
      expired = 1'b0;
      if (clear) begin
         count_d = RELOAD;
      end else if (enable) begin
         if (count_q == '0) begin
            expired = 1'b1;
            count_d = RELOAD;
         end else begin
            count_d = count_q - CW'(1);
         end
      end
   end

   // Counter register.
   always_ff @(posedge clk_100MHz) begin
      if (reset) count_q <= RELOAD;
      else       count_q <= count_d;
   end

endmodule

// File: rtl/uart_frame_controller.sv
// Assembles UART bytes into checksummed command frames and holds each valid
// frame for the consumer until a valid/ready handshake.
//
// state   | meaning
// IDLE    | hunting for SOF, other bytes dropped silently
// CMD     | next byte is the command code
// LEN     | next byte is the payload length
// PAYLOAD | collecting payload bytes into the buffer
// CHECK   | next byte is the XOR checksum
// HOLD    | frame offered on cmd_valid; incoming bytes are overruns
module uart_frame_controller
   import uart_frame_pkg::*;
#(
   parameter int DBITS          = 8,
   parameter int MAX_LEN        = DEFAULT_MAX_LEN,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int LW             = $clog2(MAX_LEN + 1),
   parameter int AW             = $clog2(MAX_LEN)
) (
   input  logic             clk_100MHz,
   input  logic             reset,
   input  logic             rx_done,
   input  logic [DBITS-1:0] rx_byte,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic [7:0]       cmd_code,
   output logic [LW-1:0]    cmd_len,
   input  logic [AW-1:0]    rd_addr,
   output logic [7:0]       rd_data,
   output logic             err_checksum,
   output logic             err_length,
   output logic             err_timeout,
   output logic             overrun
);

   frame_state_t     state_q, state_d;
   logic [7:0]       cmd_sh_q, cmd_sh_d;
   logic [LW-1:0]    len_sh_q, len_sh_d;
   logic [LW-1:0]    idx_q, idx_d;
   logic [7:0]       xor_q, xor_d;
   logic [7:0]       cmd_code_q, cmd_code_d;
   logic [LW-1:0]    cmd_len_q, cmd_len_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic             err_checksum_q, err_checksum_d;
   logic             err_length_q, err_length_d;
   logic             err_timeout_q, err_timeout_d;
   logic             overrun_q, overrun_d;
   logic             buf_we;
   logic             timer_en, timer_expired;
   logic [7:0]       pay_buf_q [MAX_LEN];

   assign timer_en = (state_q == CMD) || (state_q == LEN) ||
                     (state_q == PAYLOAD) || (state_q == CHECK);

   frame_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .clear      (rx_done),
      .enable     (timer_en),
      .expired    (timer_expired)
   );

   // Next-state, frame shadows and error pulses.
   always_comb begin
      state_d        = state_q;
      cmd_sh_d       = cmd_sh_q;
      len_sh_d       = len_sh_q;
      idx_d          = idx_q;
      xor_d          = xor_q;
      cmd_code_d     = cmd_code_q;
      cmd_len_d      = cmd_len_q;
      err_checksum_d = 1'b0;
      err_length_d   = 1'b0;
      err_timeout_d  = 1'b0;
      overrun_d      = 1'b0;
      buf_we         = 1'b0;
      case (state_q)
         IDLE: if (rx_done && rx_byte == SOF_BYTE) begin
            xor_d   = '0;
            state_d = CMD;
         end
         CMD: if (rx_done) begin
            cmd_sh_d = rx_byte;
            xor_d    = xor_q ^ rx_byte;
            state_d  = LEN;
         end
         LEN: if (rx_done) begin
            xor_d = xor_q ^ rx_byte;
            if (rx_byte > DBITS'(MAX_LEN)) begin
               err_length_d = 1'b1;
               state_d      = IDLE;
            end else begin
               len_sh_d = rx_byte[LW-1:0];
               idx_d    = '0;
               state_d  = (rx_byte == '0) ? CHECK : PAYLOAD;
            end
         end
         PAYLOAD: if (rx_done) begin
            buf_we = 1'b1;
            xor_d  = xor_q ^ rx_byte;
            idx_d  = idx_q + LW'(1);
            if (idx_q == len_sh_q - LW'(1)) state_d = CHECK;
         end
         CHECK: if (rx_done) begin
            if (rx_byte == xor_q) begin
               cmd_code_d = cmd_sh_q;
               cmd_len_d  = len_sh_q;
               state_d    = HOLD;
            end else begin
               err_checksum_d = 1'b1;
               state_d        = IDLE;
            end
         end
         HOLD: begin
            overrun_d = rx_done;
            if (cmd_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Expiry only fires without a byte in the same cycle, so it never
      // competes with the byte handling above.
      if (timer_expired) begin
         err_timeout_d = 1'b1;
         state_d       = IDLE;
      end
      cmd_valid_d = (state_d == HOLD);
   end

   // Control and output registers.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state_q        <= IDLE;
         cmd_sh_q       <= '0;
         len_sh_q       <= '0;
         idx_q          <= '0;
         xor_q          <= '0;
         cmd_code_q     <= '0;
         cmd_len_q      <= '0;
         cmd_valid_q    <= 1'b0;
         err_checksum_q <= 1'b0;
         err_length_q   <= 1'b0;
         err_timeout_q  <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cmd_sh_q       <= cmd_sh_d;
         len_sh_q       <= len_sh_d;
         idx_q          <= idx_d;
         xor_q          <= xor_d;
         cmd_code_q     <= cmd_code_d;
         cmd_len_q      <= cmd_len_d;
         cmd_valid_q    <= cmd_valid_d;
         err_checksum_q <= err_checksum_d;
         err_length_q   <= err_length_d;
         err_timeout_q  <= err_timeout_d;
         overrun_q      <= overrun_d;
      end
   end

   // Payload buffer, deliberately not reset; rd_data masking covers stale data.
   always_ff @(posedge clk_100MHz) begin
      if (buf_we) pay_buf_q[idx_q[AW-1:0]] <= rx_byte;
   end

   assign rd_data      = (LW'(rd_addr) < cmd_len_q) ? pay_buf_q[rd_addr] : 8'h00;
   assign cmd_valid    = cmd_valid_q;
   assign cmd_code     = cmd_code_q;
   assign cmd_len      = cmd_len_q;
   assign err_checksum = err_checksum_q;
   assign err_length   = err_length_q;
   assign err_timeout  = err_timeout_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_frame_controller.sv
// Directed bench for uart_frame_controller with a short inter-byte timeout.
module tb_uart_frame_controller;

   logic       clk_100MHz = 1'b0;
   logic       reset      = 1'b1;
   logic       rx_done    = 1'b0;
   logic [7:0] rx_byte    = 8'h00;
   logic       cmd_ready  = 1'b0;
   logic [2:0] rd_addr    = 3'd0;
   logic       cmd_valid;
   logic [7:0] cmd_code;
   logic [3:0] cmd_len;
   logic [7:0] rd_data;
   logic       err_checksum, err_length, err_timeout, overrun;

   int errors = 0;
   int checks = 0;

   uart_frame_controller #(.MAX_LEN(8), .TIMEOUT_CYCLES(50)) dut (
      .clk_100MHz   (clk_100MHz),
      .reset        (reset),
      .rx_done      (rx_done),
      .rx_byte      (rx_byte),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_code     (cmd_code),
      .cmd_len      (cmd_len),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .err_checksum (err_checksum),
      .err_length   (err_length),
      .err_timeout  (err_timeout),
      .overrun      (overrun)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   task automatic tick();
      @(posedge clk_100MHz);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_done = 1'b1;
      rx_byte = b;
      tick();
      rx_done = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
      rd_addr = a;
      #1;
      chk(tag, {24'h0, rd_data}, {24'h0, exp});
   endtask

   int to_count;
   int to_first;

   initial begin
      // Reset values
      tick(); tick();
      reset = 1'b0;
      chk("rst_valid", {31'h0, cmd_valid}, 0);
      chk("rst_code", {24'h0, cmd_code}, 32'h00);
      chk("rst_len", {28'h0, cmd_len}, 0);
      chk_rd("rst_rd", 3'd0, 8'h00);
      chk("rst_errs", {28'h0, err_checksum, err_length, err_timeout, overrun}, 0);

      // Valid frame, consumer ready
      cmd_ready = 1'b1;
      send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44); send(8'h65);
      chk("f1_valid", {31'h0, cmd_valid}, 1);
      chk("f1_code", {24'h0, cmd_code}, 32'h10);
      chk("f1_len", {28'h0, cmd_len}, 2);
      chk_rd("f1_rd0", 3'd0, 8'h33);
      chk_rd("f1_rd1", 3'd1, 8'h44);
      chk_rd("f1_rd2", 3'd2, 8'h00);
      tick();
      chk("f1_idle", {31'h0, cmd_valid}, 0);

      // Zero-length frame held while consumer stalls; SOF during hold is overrun
      cmd_ready = 1'b0;
      send(8'hA5); send(8'h01); send(8'h00); send(8'h01);
      chk("z_valid", {31'h0, cmd_valid}, 1);
      chk("z_code", {24'h0, cmd_code}, 32'h01);
      chk("z_len", {28'h0, cmd_len}, 0);
      chk_rd("z_rd0", 3'd0, 8'h00);
      repeat (5) tick();
      send(8'hA5);
      chk("z_overrun", {31'h0, overrun}, 1);
      chk("z_valid_ovr", {31'h0, cmd_valid}, 1);
      tick();
      chk("z_overrun_end", {31'h0, overrun}, 0);
      repeat (12) tick();
      chk("z_hold_valid", {31'h0, cmd_valid}, 1);
      chk("z_hold_code", {24'h0, cmd_code}, 32'h01);
      cmd_ready = 1'b1;
      tick();
      chk("z_idle", {31'h0, cmd_valid}, 0);
      chk("z_code_kept", {24'h0, cmd_code}, 32'h01);

      // Bad checksum, then noise before a good frame
      send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44); send(8'h66);
      chk("cs_err", {31'h0, err_checksum}, 1);
      chk("cs_valid", {31'h0, cmd_valid}, 0);
      tick();
      chk("cs_err_end", {31'h0, err_checksum}, 0);
      send(8'h00); send(8'hFF);
      send(8'hA5); send(8'h20); send(8'h01); send(8'h7E); send(8'h5F);
      chk("n_valid", {31'h0, cmd_valid}, 1);
      chk("n_code", {24'h0, cmd_code}, 32'h20);
      chk("n_len", {28'h0, cmd_len}, 1);
      chk_rd("n_rd0", 3'd0, 8'h7E);
      tick();

      // Length error; trailing bytes ignored until next SOF
      send(8'hA5); send(8'h10); send(8'h09);
      chk("len_err", {31'h0, err_length}, 1);
      send(8'h33); send(8'h44); send(8'h65);
      chk("len_after", {29'h0, cmd_valid, err_length, err_checksum}, 0);
      send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44); send(8'h65);
      chk("len_recover", {31'h0, cmd_valid}, 1);
      tick();

      // Timeout after CMD byte: fires once, 51st cycle after the last strobe
      to_count = 0;
      to_first = 0;
      send(8'hA5); send(8'h10);
      for (int k = 1; k <= 70; k++) begin
         if (err_timeout) begin
            to_count++;
            if (to_first == 0) to_first = k;
         end
         tick();
      end
      chk("to_count", to_count, 1);
      chk("to_cycle", to_first, 51);

      // Byte landing on the expiry cycle wins
      cmd_ready = 1'b0;
      to_count  = 0;
      send(8'hA5); send(8'h10);
      for (int k = 1; k < 50; k++) begin
         if (err_timeout) to_count++;
         tick();
      end
      send(8'h02);
      if (err_timeout) to_count++;
      send(8'h33); send(8'h44); send(8'h65);
      for (int k = 0; k < 60; k++) begin
         if (err_timeout) to_count++;
         tick();
      end
      chk("edge_no_to", to_count, 0);
      chk("edge_valid", {31'h0, cmd_valid}, 1);
      cmd_ready = 1'b1;
      tick();
      chk("edge_idle", {31'h0, cmd_valid}, 0);

      // Reset mid-payload, then a full frame
      send(8'hA5); send(8'h30); send(8'h03); send(8'h11);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mr_valid", {31'h0, cmd_valid}, 0);
      chk("mr_code", {24'h0, cmd_code}, 32'h00);
      chk("mr_len", {28'h0, cmd_len}, 0);
      chk_rd("mr_rd0", 3'd0, 8'h00);
      cmd_ready = 1'b0;
      send(8'hA5); send(8'h30); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h33);
      chk("mr2_valid", {31'h0, cmd_valid}, 1);
      chk("mr2_code", {24'h0, cmd_code}, 32'h30);
      chk("mr2_len", {28'h0, cmd_len}, 3);
      chk_rd("mr2_rd1", 3'd1, 8'h22);
      chk_rd("mr2_rd2", 3'd2, 8'h33);
      chk_rd("mr2_rd3", 3'd3, 8'h00);
      cmd_ready = 1'b1;
      tick();
      chk("mr2_idle", {31'h0, cmd_valid}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
